// File: rtl/serial_word_loader.sv
// Serial word loader: deserialises a slow strobed bit stream into words and
// emits one write pulse per word into code or data memory with auto-incrementing
// address. Framing, mode, memory-full and timeout faults park the block in FAULT.
module serial_word_loader #(
  parameter int unsigned WORD_BITS = 32,
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_code_load,
  input  logic                 en_data_load,
  input  logic                 sent_clk,
  input  logic                 data_bit,
  output logic                 wr_en,
  output logic                 wr_code,
  output logic                 wr_data,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [WORD_BITS-1:0] wr_word,
  output logic [ADDR_BITS:0]   word_cnt,
  output logic                 busy,
  output logic                 fault
);

  localparam int unsigned BW = $clog2(WORD_BITS);
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StLoad, StFault} state_e;

  state_e               state_q, state_d;
  logic                 clk_s1_q, clk_s2_q, clk_s3_q;
  logic                 dat_s1_q, dat_s2_q;
  logic                 strobe;
  logic [WORD_BITS-1:0] shift_q, shift_d, shift_nxt;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 mode_code_q, mode_code_d;
  logic                 wr_en_q, wr_en_d;
  logic                 wr_code_q, wr_code_d;
  logic                 wr_data_q, wr_data_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_BITS-1:0] wr_word_q, wr_word_d;
  logic [ADDR_BITS:0]   word_cnt_q, word_cnt_d;
  logic                 fault_q, fault_d;
  logic                 mode_en, other_en;

  assign strobe    = clk_s2_q & ~clk_s3_q;
  assign shift_nxt = {shift_q[WORD_BITS-2:0], dat_s2_q};
  assign mode_en   = mode_code_q ? en_code_load : en_data_load;
  assign other_en  = mode_code_q ? en_data_load : en_code_load;

  // Synchronisers, FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1_q    <= 1'b0;
      clk_s2_q    <= 1'b0;
      clk_s3_q    <= 1'b0;
      dat_s1_q    <= 1'b0;
      dat_s2_q    <= 1'b0;
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      timer_q     <= '0;
      addr_q      <= '0;
      mode_code_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_code_q   <= 1'b0;
      wr_data_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_word_q   <= '0;
      word_cnt_q  <= '0;
      fault_q     <= 1'b0;
    end else begin
      clk_s1_q    <= sent_clk;
      clk_s2_q    <= clk_s1_q;
      clk_s3_q    <= clk_s2_q;
      dat_s1_q    <= data_bit;
      dat_s2_q    <= dat_s1_q;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      timer_q     <= timer_d;
      addr_q      <= addr_d;
      mode_code_q <= mode_code_d;
      wr_en_q     <= wr_en_d;
      wr_code_q   <= wr_code_d;
      wr_data_q   <= wr_data_d;
      wr_addr_q   <= wr_addr_d;
      wr_word_q   <= wr_word_d;
      word_cnt_q  <= word_cnt_d;
      fault_q     <= fault_d;
    end
  end

  // Next-state logic: session start, bit assembly, word write and fault detection.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    timer_d     = timer_q;
    addr_d      = addr_q;
    mode_code_d = mode_code_q;
    wr_en_d     = 1'b0;
    wr_code_d   = wr_code_q;
    wr_data_d   = wr_data_q;
    wr_addr_d   = wr_addr_q;
    wr_word_d   = wr_word_q;
    word_cnt_d  = word_cnt_q;
    fault_d     = fault_q;

    unique case (state_q)
      StIdle: begin
        if (en_code_load ^ en_data_load) begin
          state_d     = StLoad;
          mode_code_d = en_code_load;
          word_cnt_d  = '0;
          addr_d      = '0;
          bit_cnt_d   = '0;
          timer_d     = '0;
          shift_d     = '0;
          fault_d     = 1'b0;
        end else if (en_code_load && en_data_load) begin
          state_d = StFault;
          fault_d = 1'b1;
        end
      end
      StLoad: begin
        // Enable changes take priority over a coincident strobe.
        if (other_en || (!mode_en && (bit_cnt_q != '0))) begin
          state_d = StFault;
        end else if (!mode_en) begin
          state_d = StIdle;
        end else if (strobe) begin
          if (word_cnt_q[ADDR_BITS]) begin
            // Memory already holds 2**ADDR_BITS words; never wrap.
            state_d = StFault;
          end else begin
            shift_d = shift_nxt;
            timer_d = '0;
            if (bit_cnt_q == BW'(WORD_BITS - 1)) begin
              wr_en_d    = 1'b1;
              wr_word_d  = shift_nxt;
              wr_addr_d  = addr_q;
              wr_code_d  = mode_code_q;
              wr_data_d  = ~mode_code_q;
              addr_d     = addr_q + 1'b1;
              word_cnt_d = word_cnt_q + 1'b1;
              bit_cnt_d  = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end else if (bit_cnt_q != '0) begin
          if (timer_q == TW'(TIMEOUT - 1)) begin
            state_d = StFault;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        // Any move to FAULT discards the partial word.
        if (state_d == StFault) begin
          fault_d   = 1'b1;
          bit_cnt_d = '0;
          timer_d   = '0;
          shift_d   = '0;
        end
      end
      StFault: begin
        if (!en_code_load && !en_data_load) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign wr_en    = wr_en_q;
  assign wr_code  = wr_code_q;
  assign wr_data  = wr_data_q;
  assign wr_addr  = wr_addr_q;
  assign wr_word  = wr_word_q;
  assign word_cnt = word_cnt_q;
  assign busy     = (state_q == StLoad);
  assign fault    = fault_q;

endmodule

// File: tb/tb_serial_word_loader.sv
// Scoreboard bench for serial_word_loader: expected writes are queued by the
// stimulus, a negedge monitor pops and compares on every wr_en pulse.
module tb_serial_word_loader;

  localparam int unsigned WB = 32;
  localparam int unsigned AB = 2;
  localparam int unsigned TO = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en_code_load = 1'b0;
  logic          en_data_load = 1'b0;
  logic          sent_clk = 1'b0;
  logic          data_bit = 1'b0;
  logic          wr_en, wr_code, wr_data, busy, fault;
  logic [AB-1:0] wr_addr;
  logic [WB-1:0] wr_word;
  logic [AB:0]   word_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic          code;
    logic [AB-1:0] addr;
    logic [WB-1:0] word;
  } exp_t;
  exp_t exp_q[$];

  serial_word_loader #(.WORD_BITS(WB), .ADDR_BITS(AB), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_code_load (en_code_load),
    .en_data_load (en_data_load),
    .sent_clk     (sent_clk),
    .data_bit     (data_bit),
    .wr_en        (wr_en),
    .wr_code      (wr_code),
    .wr_data      (wr_data),
    .wr_addr      (wr_addr),
    .wr_word      (wr_word),
    .word_cnt     (word_cnt),
    .busy         (busy),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    data_bit = b;
    sent_clk = 1'b0;
    wait_clk(4);
    sent_clk = 1'b1;
    wait_clk(4);
  endtask

  task automatic send_word(input logic [WB-1:0] w);
    for (int i = WB - 1; i >= 0; i--) send_bit(w[i]);
    sent_clk = 1'b0;
  endtask

  task automatic push(input logic code, input logic [AB-1:0] addr, input logic [WB-1:0] w);
    exp_t e;
    e.code = code;
    e.addr = addr;
    e.word = w;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, {59'd0, wr_en, wr_code, wr_data, busy, fault}, 64'd0);
    check({tag, "_addr"}, {62'd0, wr_addr}, 64'd0);
    check({tag, "_word"}, {32'd0, wr_word}, 64'd0);
    check({tag, "_cnt"}, {61'd0, word_cnt}, 64'd0);
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h word %0h expected no write",
                 wr_addr, wr_word);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_target", {62'd0, wr_code, wr_data}, {62'd0, e.code, ~e.code});
        check("wr_addr", {62'd0, wr_addr}, {62'd0, e.addr});
        check("wr_word", {32'd0, wr_word}, {32'd0, e.word});
      end
    end
  end

  initial begin
    wait_clk(4);
    check_all_zero("reset");
    rst_n = 1'b1;
    wait_clk(2);

    // Single code word.
    en_code_load = 1'b1;
    wait_clk(2);
    check("code_busy", {63'd0, busy}, 64'd1);
    push(1'b1, 2'd0, 32'h2008_0005);
    send_word(32'h2008_0005);
    wait_clk(4);
    check("code_cnt", {61'd0, word_cnt}, 64'd1);
    en_code_load = 1'b0;
    wait_clk(3);
    check("code_end_flags", {62'd0, busy, fault}, 64'd0);
    check("code_hold_word", {32'd0, wr_word}, {32'd0, 32'h2008_0005});
    check("code_hold_cnt", {61'd0, word_cnt}, 64'd1);

    // Three data words then clean end.
    en_data_load = 1'b1;
    wait_clk(2);
    push(1'b0, 2'd0, 32'h0000_0001);
    push(1'b0, 2'd1, 32'hFFFF_FFFF);
    push(1'b0, 2'd2, 32'hA5A5_A5A5);
    send_word(32'h0000_0001);
    send_word(32'hFFFF_FFFF);
    send_word(32'hA5A5_A5A5);
    wait_clk(4);
    en_data_load = 1'b0;
    wait_clk(3);
    check("data_end_flags", {62'd0, busy, fault}, 64'd0);
    check("data_cnt", {61'd0, word_cnt}, 64'd3);

    // Enable dropped mid-word.
    en_code_load = 1'b1;
    wait_clk(2);
    for (int i = 0; i < 17; i++) send_bit(i[0]);
    sent_clk = 1'b0;
    en_code_load = 1'b0;
    wait_clk(3);
    check("partial_fault", {62'd0, busy, fault}, 64'd1);
    en_code_load = 1'b1;
    wait_clk(3);
    check("restart_clears", {62'd0, busy, fault}, 64'd2);
    en_code_load = 1'b0;
    wait_clk(3);

    // Both enables together.
    en_code_load = 1'b1;
    en_data_load = 1'b1;
    wait_clk(3);
    check("both_fault", {62'd0, busy, fault}, 64'd1);
    send_word(32'h1234_5678);
    wait_clk(4);
    check("both_still_fault", {62'd0, busy, fault}, 64'd1);
    en_code_load = 1'b0;
    en_data_load = 1'b0;
    wait_clk(3);
    check("idle_fault_sticky", {63'd0, fault}, 64'd1);

    // Fill memory (4 words), then one more strobe.
    en_data_load = 1'b1;
    wait_clk(2);
    for (int k = 0; k < 4; k++) push(1'b0, AB'(k), {8{4'(k + 1)}});
    for (int k = 0; k < 4; k++) send_word({8{4'(k + 1)}});
    wait_clk(4);
    check("full_cnt", {61'd0, word_cnt}, 64'd4);
    check("full_no_fault", {63'd0, fault}, 64'd0);
    send_bit(1'b1);
    sent_clk = 1'b0;
    wait_clk(2);
    check("overflow_fault", {62'd0, busy, fault}, 64'd1);
    check("overflow_cnt", {61'd0, word_cnt}, 64'd4);
    en_data_load = 1'b0;
    wait_clk(3);

    // Stall inside a word.
    en_code_load = 1'b1;
    wait_clk(2);
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    sent_clk = 1'b0;
    wait_clk(TO - 50);
    check("before_timeout", {62'd0, busy, fault}, 64'd2);
    wait_clk(70);
    check("timeout_fault", {62'd0, busy, fault}, 64'd1);
    en_code_load = 1'b0;
    wait_clk(3);

    // Reset mid-word, then a fresh word starts cleanly at address 0.
    en_code_load = 1'b1;
    wait_clk(2);
    for (int i = 0; i < 10; i++) send_bit(1'b0);
    sent_clk = 1'b0;
    check("midword_busy", {63'd0, busy}, 64'd1);
    en_code_load = 1'b0;
    rst_n = 1'b0;
    wait_clk(1);
    check_all_zero("midword_reset");
    rst_n = 1'b1;
    wait_clk(2);
    en_code_load = 1'b1;
    wait_clk(2);
    push(1'b1, 2'd0, 32'hDEAD_BEEF);
    send_word(32'hDEAD_BEEF);
    wait_clk(4);
    check("post_reset_cnt", {61'd0, word_cnt}, 64'd1);
    en_code_load = 1'b0;
    wait_clk(3);

    check("pending_writes", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
